// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pipeline_hazard_ctrl: stall/flush sequencer for load-use, multi-cycle       |
// | multiply, taken-branch squash and debug halt/drain; counts stall cycles.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module pipeline_hazard_ctrl #(
  parameter int unsigned MUL_LAT      = 4,
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter logic [4:0]  ZERO_REG     = 5'd31
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  id_rn,
  input  logic [4:0]  id_rm,
  input  logic        id_uses_rn,
  input  logic        id_uses_rm,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_rd,
  input  logic        ex_mul,
  input  logic        ex_branch_taken,
  input  logic        halt_req,
  output logic        pc_write,
  output logic        if_id_write,
  output logic        if_id_flush,
  output logic        id_ex_bubble,
  output logic        id_ex_hold,
  output logic        ex_mem_bubble,
  output logic        halted,
  output logic [15:0] stall_cycles
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MUL_BUSY = 2'd1,
    DRAIN    = 2'd2,
    HALTED   = 2'd3
  } state_t;

  localparam bit         MUL_STALLS   = (MUL_LAT > 1);
  localparam logic [3:0] MUL_CNT_INIT = MUL_STALLS ? 4'(MUL_LAT - 2) : 4'd0;
  localparam logic [3:0] DRAIN_INIT   = 4'(DRAIN_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] stall_q, stall_d;

  logic load_use;
  logic pc_write_c, if_id_write_c, if_id_flush_c, id_ex_bubble_c;
  logic id_ex_hold_c, ex_mem_bubble_c, halted_c;

  assign load_use = ex_mem_read && (ex_rd != ZERO_REG) &&
                    ((id_uses_rn && (id_rn == ex_rd)) ||
                     (id_uses_rm && (id_rm == ex_rd)));

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    pc_write_c      = 1'b1;
    if_id_write_c   = 1'b1;
    if_id_flush_c   = 1'b0;
    id_ex_bubble_c  = 1'b0;
    id_ex_hold_c    = 1'b0;
    ex_mem_bubble_c = 1'b0;
    halted_c        = 1'b0;

    case (state_q)
      RUN: begin
        if (ex_branch_taken) begin
          if_id_flush_c  = 1'b1;
          id_ex_bubble_c = 1'b1;
        end else if (ex_mul && MUL_STALLS) begin
          pc_write_c      = 1'b0;
          if_id_write_c   = 1'b0;
          id_ex_hold_c    = 1'b1;
          ex_mem_bubble_c = 1'b1;
          cnt_d           = MUL_CNT_INIT;
          state_d         = MUL_BUSY;
        end else if (halt_req) begin
          pc_write_c     = 1'b0;
          if_id_write_c  = 1'b0;
          id_ex_bubble_c = 1'b1;
          cnt_d          = DRAIN_INIT;
          state_d        = DRAIN;
        end else if (load_use) begin
          pc_write_c     = 1'b0;
          if_id_write_c  = 1'b0;
          id_ex_bubble_c = 1'b1;
        end
      end

      MUL_BUSY: begin
        if (cnt_q != 4'd0) begin
          pc_write_c      = 1'b0;
          if_id_write_c   = 1'b0;
          id_ex_hold_c    = 1'b1;
          ex_mem_bubble_c = 1'b1;
          cnt_d           = cnt_q - 4'd1;
        end else begin
          // Result leaves EX this cycle; the still-asserted ex_mul must not re-trigger.
          state_d = RUN;
          if (ex_branch_taken) begin
            if_id_flush_c  = 1'b1;
            id_ex_bubble_c = 1'b1;
          end else if (load_use) begin
            pc_write_c     = 1'b0;
            if_id_write_c  = 1'b0;
            id_ex_bubble_c = 1'b1;
          end
        end
      end

      DRAIN: begin
        pc_write_c     = 1'b0;
        if_id_write_c  = 1'b0;
        id_ex_bubble_c = 1'b1;
        if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
        else               state_d = HALTED;
      end

      HALTED: begin
        halted_c       = 1'b1;
        pc_write_c     = 1'b0;
        if_id_write_c  = 1'b0;
        id_ex_bubble_c = 1'b1;
        if (!halt_req) state_d = RUN;
      end

      default: state_d = RUN;
    endcase
  end

  always_comb begin
    stall_d = stall_q;
    if (!pc_write_c && (state_q != HALTED) && (stall_q != 16'hFFFF))
      stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= 4'd0;
      stall_q <= 16'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
    end
  end

  // Reset overrides the Mealy outputs immediately, without waiting for an edge.
  assign pc_write      = rst_n & pc_write_c;
  assign if_id_write   = rst_n & if_id_write_c;
  assign if_id_flush   = rst_n & if_id_flush_c;
  assign id_ex_bubble  = ~rst_n | id_ex_bubble_c;
  assign id_ex_hold    = rst_n & id_ex_hold_c;
  assign ex_mem_bubble = rst_n & ex_mem_bubble_c;
  assign halted        = rst_n & halted_c;
  assign stall_cycles  = stall_q;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_pipeline_hazard_ctrl: directed self-checking bench for the hazard ctrl. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_pipeline_hazard_ctrl;

  // Output vector order: {pc_write, if_id_write, if_id_flush, id_ex_bubble,
  //                       id_ex_hold, ex_mem_bubble, halted}
  localparam logic [6:0] O_DEF    = 7'b1100000;
  localparam logic [6:0] O_STALL  = 7'b0001000;
  localparam logic [6:0] O_BRANCH = 7'b1111000;
  localparam logic [6:0] O_MUL    = 7'b0000110;
  localparam logic [6:0] O_HALTED = 7'b0001001;
  localparam logic [6:0] O_RST    = 7'b0001000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  id_rn, id_rm, ex_rd;
  logic        id_uses_rn, id_uses_rm, ex_mem_read, ex_mul, ex_branch_taken, halt_req;
  logic        pc_write, if_id_write, if_id_flush, id_ex_bubble, id_ex_hold;
  logic        ex_mem_bubble, halted;
  logic [15:0] stall_cycles;
  logic [6:0]  outs;

  int total = 0;
  int bad   = 0;
  logic [15:0] exp_stall;

  pipeline_hazard_ctrl #(.MUL_LAT(4), .DRAIN_CYCLES(3), .ZERO_REG(5'd31)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .id_rn           (id_rn),
    .id_rm           (id_rm),
    .id_uses_rn      (id_uses_rn),
    .id_uses_rm      (id_uses_rm),
    .ex_mem_read     (ex_mem_read),
    .ex_rd           (ex_rd),
    .ex_mul          (ex_mul),
    .ex_branch_taken (ex_branch_taken),
    .halt_req        (halt_req),
    .pc_write        (pc_write),
    .if_id_write     (if_id_write),
    .if_id_flush     (if_id_flush),
    .id_ex_bubble    (id_ex_bubble),
    .id_ex_hold      (id_ex_hold),
    .ex_mem_bubble   (ex_mem_bubble),
    .halted          (halted),
    .stall_cycles    (stall_cycles)
  );

  assign outs = {pc_write, if_id_write, if_id_flush, id_ex_bubble,
                 id_ex_hold, ex_mem_bubble, halted};

  always #5 clk = ~clk;

  task automatic idle_inputs();
    id_rn = 5'd0; id_rm = 5'd0; ex_rd = 5'd0;
    id_uses_rn = 1'b0; id_uses_rm = 1'b0; ex_mem_read = 1'b0;
    ex_mul = 1'b0; ex_branch_taken = 1'b0; halt_req = 1'b0;
  endtask

  // Advance to just after the next rising edge; inputs change here, checks follow #1 later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    #3;
    total++;
    if (outs !== O_RST) begin
      bad++; $display("FAIL reset_outs got=%b want=%b", outs, O_RST);
    end
    total++;
    if (stall_cycles !== 16'd0) begin
      bad++; $display("FAIL reset_stall got=%0d want=0", stall_cycles);
    end
    step(); step();
    rst_n = 1'b1;
    #1;
    total++;
    if (outs !== O_DEF) begin
      bad++; $display("FAIL post_reset_default got=%b want=%b", outs, O_DEF);
    end
    exp_stall = 16'd0;
  endtask

  task automatic test_load_use();
    ex_mem_read = 1'b1; ex_rd = 5'd3; id_rn = 5'd3; id_uses_rn = 1'b1;
    #1;
    total++;
    if (outs !== O_STALL) begin
      bad++; $display("FAIL load_use_rn got=%b want=%b", outs, O_STALL);
    end
    step(); exp_stall = exp_stall + 16'd1;
    ex_mem_read = 1'b0;
    #1;
    total++;
    if (outs !== O_DEF) begin
      bad++; $display("FAIL load_use_release got=%b want=%b", outs, O_DEF);
    end
    total++;
    if (stall_cycles !== exp_stall) begin
      bad++; $display("FAIL load_use_stall got=%0d want=%0d", stall_cycles, exp_stall);
    end
    ex_mem_read = 1'b1; ex_rd = 5'd7; id_rm = 5'd7; id_uses_rm = 1'b1; id_uses_rn = 1'b0;
    #1;
    total++;
    if (outs !== O_STALL) begin
      bad++; $display("FAIL load_use_rm got=%b want=%b", outs, O_STALL);
    end
    step(); exp_stall = exp_stall + 16'd1;
    idle_inputs();
  endtask

  task automatic test_no_hazard();
    ex_mem_read = 1'b1; ex_rd = 5'd31; id_rm = 5'd31; id_uses_rm = 1'b1;
    #1;
    total++;
    if (outs !== O_DEF) begin
      bad++; $display("FAIL xzr_no_stall got=%b want=%b", outs, O_DEF);
    end
    step();
    id_uses_rm = 1'b0; ex_rd = 5'd5; id_rn = 5'd5; id_uses_rn = 1'b0;
    #1;
    total++;
    if (outs !== O_DEF) begin
      bad++; $display("FAIL unused_rn_no_stall got=%b want=%b", outs, O_DEF);
    end
    step();
    total++;
    if (stall_cycles !== exp_stall) begin
      bad++; $display("FAIL no_hazard_stall got=%0d want=%0d", stall_cycles, exp_stall);
    end
    idle_inputs();
  endtask

  task automatic test_multiply();
    ex_mul = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if (outs !== O_MUL) begin
        bad++; $display("FAIL mul_stall_%0d got=%b want=%b", i, outs, O_MUL);
      end
      step();
    end
    exp_stall = exp_stall + 16'd3;
    #1;
    total++;
    if (outs !== O_DEF) begin
      bad++; $display("FAIL mul_free_cycle got=%b want=%b", outs, O_DEF);
    end
    ex_mul = 1'b0;
    step();
    total++;
    if (outs !== O_DEF) begin
      bad++; $display("FAIL mul_back_to_run got=%b want=%b", outs, O_DEF);
    end
    total++;
    if (stall_cycles !== exp_stall) begin
      bad++; $display("FAIL mul_stall_count got=%0d want=%0d", stall_cycles, exp_stall);
    end
  endtask

  task automatic test_priority();
    ex_branch_taken = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd3;
    id_rn = 5'd3; id_uses_rn = 1'b1; halt_req = 1'b1;
    #1;
    total++;
    if (outs !== O_BRANCH) begin
      bad++; $display("FAIL prio_branch got=%b want=%b", outs, O_BRANCH);
    end
    step();
    ex_branch_taken = 1'b0; ex_mem_read = 1'b0;
    #1;
    total++;
    if (outs !== O_STALL) begin
      bad++; $display("FAIL prio_halt_entry got=%b want=%b", outs, O_STALL);
    end
    step();
    // Dropping the request inside DRAIN must not abort the drain.
    halt_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if (outs !== O_STALL) begin
        bad++; $display("FAIL prio_drain_%0d got=%b want=%b", i, outs, O_STALL);
      end
      step();
    end
    #1;
    total++;
    if (outs !== O_HALTED) begin
      bad++; $display("FAIL prio_halted got=%b want=%b", outs, O_HALTED);
    end
    step();
    exp_stall = exp_stall + 16'd4;
    total++;
    if (outs !== O_DEF || stall_cycles !== exp_stall) begin
      bad++; $display("FAIL prio_resume got=%b/%0d want=%b/%0d",
                      outs, stall_cycles, O_DEF, exp_stall);
    end
    idle_inputs();
  endtask

  task automatic test_halt();
    halt_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++;
      if (outs !== O_STALL) begin
        bad++; $display("FAIL halt_drain_%0d got=%b want=%b", i, outs, O_STALL);
      end
      step();
    end
    exp_stall = exp_stall + 16'd4;
    for (int i = 0; i < 5; i++) begin
      #1;
      total++;
      if (outs !== O_HALTED) begin
        bad++; $display("FAIL halt_hold_%0d got=%b want=%b", i, outs, O_HALTED);
      end
      step();
    end
    halt_req = 1'b0;
    #1;
    total++;
    if (outs !== O_HALTED) begin
      bad++; $display("FAIL halt_release_cycle got=%b want=%b", outs, O_HALTED);
    end
    step();
    total++;
    if (outs !== O_DEF) begin
      bad++; $display("FAIL halt_resume got=%b want=%b", outs, O_DEF);
    end
    total++;
    if (stall_cycles !== exp_stall) begin
      bad++; $display("FAIL halt_stall_count got=%0d want=%0d", stall_cycles, exp_stall);
    end
  endtask

  task automatic test_async_reset();
    ex_mul = 1'b1;
    step();
    step();
    #1;
    total++;
    if (outs !== O_MUL) begin
      bad++; $display("FAIL areset_pre_mul got=%b want=%b", outs, O_MUL);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (outs !== O_RST) begin
      bad++; $display("FAIL areset_outs got=%b want=%b", outs, O_RST);
    end
    total++;
    if (stall_cycles !== 16'd0) begin
      bad++; $display("FAIL areset_stall got=%0d want=0", stall_cycles);
    end
    ex_mul = 1'b0;
    step();
    rst_n = 1'b1;
    exp_stall = 16'd0;
    #1;
    total++;
    if (outs !== O_DEF || stall_cycles !== exp_stall) begin
      bad++; $display("FAIL areset_release got=%b/%0d want=%b/0", outs, stall_cycles, O_DEF);
    end
    step();
    total++;
    if (outs !== O_DEF) begin
      bad++; $display("FAIL areset_no_residual got=%b want=%b", outs, O_DEF);
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_no_hazard();
    test_multiply();
    test_priority();
    test_halt();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
